cereal_rx: RTL and testbench

CEREAL_RX -- requirements
Module: cereal_rx

---
 rtl/cereal_rx.sv | 152 +++++++++++++++
 tb/tb_cereal_rx.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/cereal_rx.sv
`default_nettype none
// cereal_rx: 8N1 serial receiver with 2-flop synchronizer, start-glitch reject and error pulses.
// Optional even-parity bit enabled by defining CEREAL_RX_PARITY_EN. Rev 1.0
module cereal_rx #(
   parameter int CLKS_PER_BIT = 5208
) (
   input  logic       sysclk,
   input  logic       rst_n,
   input  logic       cereal,
   output logic [7:0] data,
   output logic       valid,
   output logic       busy,
   output logic       frame_err,
   output logic       parity_err
);

   localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
`ifdef CEREAL_RX_PARITY_EN
      PARITY = 3'd3,
`endif
      STOP   = 3'd4,
      BREAK  = 3'd5
   } state_t;

   state_t      state;
   logic        sync_meta;
   logic        sync_line;
   logic [15:0] cnt;
   logic [2:0]  idx;
   logic [7:0]  shreg;
`ifdef CEREAL_RX_PARITY_EN
   logic        par_bad;
`else
   assign parity_err = 1'b0;
`endif

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         sync_meta  <= 1'b1;
         sync_line  <= 1'b1;
         state      <= IDLE;
         cnt        <= 16'd0;
         idx        <= 3'd0;
         shreg      <= 8'h00;
         data       <= 8'h00;
         valid      <= 1'b0;
         busy       <= 1'b0;
         frame_err  <= 1'b0;
`ifdef CEREAL_RX_PARITY_EN
         parity_err <= 1'b0;
         par_bad    <= 1'b0;
`endif
      end else begin
         sync_meta  <= cereal;
         sync_line  <= sync_meta;
         valid      <= 1'b0;
         frame_err  <= 1'b0;
`ifdef CEREAL_RX_PARITY_EN
         parity_err <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (!sync_line) begin
                  state <= START;
                  cnt   <= 16'd0;
                  idx   <= 3'd0;
                  busy  <= 1'b1;
               end
            end
            START: begin
               // Re-check the line half a bit in; a pulse shorter than that is noise.
               if (cnt == HALF_LAST) begin
                  cnt <= 16'd0;
                  if (!sync_line) begin
                     state <= DATA;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            DATA: begin
               if (cnt == BIT_LAST) begin
                  cnt        <= 16'd0;
                  shreg[idx] <= sync_line;
                  idx        <= idx + 3'd1;
                  if (idx == 3'd7) begin
`ifdef CEREAL_RX_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
                  end
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
`ifdef CEREAL_RX_PARITY_EN
            PARITY: begin
               if (cnt == BIT_LAST) begin
                  cnt     <= 16'd0;
                  par_bad <= ^{shreg, sync_line};
                  state   <= STOP;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
`endif
            STOP: begin
               if (cnt == BIT_LAST) begin
                  cnt <= 16'd0;
                  if (sync_line) begin
                     data  <= shreg;
                     valid <= 1'b1;
`ifdef CEREAL_RX_PARITY_EN
                     parity_err <= par_bad;
`endif
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else begin
                     frame_err <= 1'b1;
                     state     <= BREAK;
                  end
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            BREAK: begin
               // Wait out a held-low line so it is not mistaken for a new start bit.
               if (sync_line) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cereal_rx.sv
`default_nettype none
// tb_cereal_rx: directed self-checking bench for cereal_rx at CLKS_PER_BIT=16.
module tb_cereal_rx;

   localparam int CPB = 16;
`ifdef CEREAL_RX_PARITY_EN
   localparam int LAT      = 171;
   localparam int BUSY_LEN = 168;
`else
   localparam int LAT      = 155;
   localparam int BUSY_LEN = 152;
`endif

   logic       sysclk = 1'b0;
   logic       rst_n  = 1'b0;
   logic       cereal = 1'b1;
   logic [7:0] data;
   logic       valid, busy, frame_err, parity_err;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc = 0, start_cyc = 0, lat = -1;
   int v_cnt = 0, fe_cnt = 0, pe_cnt = 0, same_cnt = 0, dbl_cnt = 0, busy_cnt = 0;
   logic [7:0] q[$];
   logic pv = 1'b0, pf = 1'b0, pp = 1'b0;
   logic [7:0] got;

   cereal_rx #(.CLKS_PER_BIT(CPB)) dut (
      .sysclk(sysclk), .rst_n(rst_n), .cereal(cereal), .data(data),
      .valid(valid), .busy(busy), .frame_err(frame_err), .parity_err(parity_err)
   );

   always #5 sysclk = ~sysclk;
   always @(posedge sysclk) cyc++;

   always @(negedge sysclk) begin
      if (valid) begin
         v_cnt++;
         q.push_back(data);
         if (lat < 0) lat = cyc - start_cyc;
      end
      if (frame_err) fe_cnt++;
      if (parity_err) pe_cnt++;
      if (valid && parity_err) same_cnt++;
      if ((valid && pv) || (frame_err && pf) || (parity_err && pp)) dbl_cnt++;
      if (busy) busy_cnt++;
      pv = valid; pf = frame_err; pp = parity_err;
   end

   task automatic clear_stats();
      v_cnt = 0; fe_cnt = 0; pe_cnt = 0; same_cnt = 0; busy_cnt = 0; lat = -1;
      q.delete();
   endtask

   task automatic drive_bit(input logic v);
      cereal = v;
      repeat (CPB) @(negedge sysclk);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip);
      start_cyc = cyc;
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef CEREAL_RX_PARITY_EN
      drive_bit((^b) ^ par_flip);
`else
      if (par_flip) drive_bit(1'b1);
`endif
      drive_bit(stop_bit);
   endtask

   task automatic test_reset();
      @(negedge sysclk);
      n_checks++; if (data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %0h expected 00", data); end
      n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
      n_checks++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_parity_err: got %b expected 0", parity_err); end
   endtask

   task automatic test_single();
      clear_stats();
      send_frame(8'hA5, 1'b1, 1'b0);
      repeat (20) @(negedge sysclk);
      got = (q.size() > 0) ? q[0] : 8'hxx;
      n_checks++; if (v_cnt != 1) begin n_fail++; $display("FAIL single_valid_count: got %0d expected 1", v_cnt); end
      n_checks++; if (got !== 8'hA5) begin n_fail++; $display("FAIL single_pulse_data: got %0h expected a5", got); end
      n_checks++; if (data !== 8'hA5) begin n_fail++; $display("FAIL single_data_hold: got %0h expected a5", data); end
      n_checks++; if (fe_cnt != 0) begin n_fail++; $display("FAIL single_frame_err: got %0d expected 0", fe_cnt); end
      n_checks++; if (pe_cnt != 0) begin n_fail++; $display("FAIL single_parity_err: got %0d expected 0", pe_cnt); end
      n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL single_latency: got %0d expected %0d", lat, LAT); end
      n_checks++; if (busy_cnt != BUSY_LEN) begin n_fail++; $display("FAIL single_busy_len: got %0d expected %0d", busy_cnt, BUSY_LEN); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_idle: got %b expected 0", busy); end
   endtask

   task automatic test_glitch();
      clear_stats();
      cereal = 1'b0;
      repeat (5) @(negedge sysclk);
      cereal = 1'b1;
      repeat (10) @(negedge sysclk);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy: got %b expected 0", busy); end
      repeat (20) @(negedge sysclk);
      n_checks++; if (v_cnt != 0) begin n_fail++; $display("FAIL glitch_valid: got %0d expected 0", v_cnt); end
      n_checks++; if (fe_cnt != 0) begin n_fail++; $display("FAIL glitch_frame_err: got %0d expected 0", fe_cnt); end
      n_checks++; if (busy_cnt != 8) begin n_fail++; $display("FAIL glitch_busy_len: got %0d expected 8", busy_cnt); end
   endtask

   task automatic test_frame_err();
      clear_stats();
      send_frame(8'h3C, 1'b0, 1'b0);
      repeat (40) @(negedge sysclk);
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ferr_busy_break: got %b expected 1", busy); end
      cereal = 1'b1;
      repeat (10) @(negedge sysclk);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ferr_busy_release: got %b expected 0", busy); end
      n_checks++; if (fe_cnt != 1) begin n_fail++; $display("FAIL ferr_count: got %0d expected 1", fe_cnt); end
      n_checks++; if (v_cnt != 0) begin n_fail++; $display("FAIL ferr_valid: got %0d expected 0", v_cnt); end
      n_checks++; if (data !== 8'hA5) begin n_fail++; $display("FAIL ferr_data_kept: got %0h expected a5", data); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_b [3];
      exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h55;
      clear_stats();
      for (int i = 0; i < 3; i++) send_frame(exp_b[i], 1'b1, 1'b0);
      repeat (20) @(negedge sysclk);
      n_checks++; if (v_cnt != 3) begin n_fail++; $display("FAIL b2b_count: got %0d expected 3", v_cnt); end
      for (int i = 0; i < 3; i++) begin
         got = (q.size() > i) ? q[i] : 8'hxx;
         n_checks++;
         if (got !== exp_b[i]) begin
            n_fail++; $display("FAIL b2b_data%0d: got %0h expected %0h", i, got, exp_b[i]);
         end
      end
   endtask

   task automatic test_reset_midframe();
      logic [7:0] b;
      b = 8'h81;
      clear_stats();
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(b[i]);
      cereal = b[4];
      repeat (8) @(negedge sysclk);
      rst_n = 1'b0;
      @(negedge sysclk);
      n_checks++; if (data !== 8'h00) begin n_fail++; $display("FAIL rstmid_data: got %0h expected 00", data); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
      cereal = 1'b1;
      repeat (3) @(negedge sysclk);
      rst_n = 1'b1;
      repeat (CPB * 8) @(negedge sysclk);
      n_checks++; if (v_cnt != 0) begin n_fail++; $display("FAIL rstmid_no_valid: got %0d expected 0", v_cnt); end
      n_checks++; if (fe_cnt != 0) begin n_fail++; $display("FAIL rstmid_no_ferr: got %0d expected 0", fe_cnt); end
      send_frame(8'h7E, 1'b1, 1'b0);
      repeat (20) @(negedge sysclk);
      got = (q.size() > 0) ? q[0] : 8'hxx;
      n_checks++; if (v_cnt != 1) begin n_fail++; $display("FAIL rstmid_7e_count: got %0d expected 1", v_cnt); end
      n_checks++; if (got !== 8'h7E) begin n_fail++; $display("FAIL rstmid_7e_data: got %0h expected 7e", got); end
   endtask

`ifdef CEREAL_RX_PARITY_EN
   task automatic test_parity();
      clear_stats();
      send_frame(8'h07, 1'b1, 1'b1);
      repeat (20) @(negedge sysclk);
      n_checks++; if (v_cnt != 1) begin n_fail++; $display("FAIL parity_valid: got %0d expected 1", v_cnt); end
      n_checks++; if (pe_cnt != 1) begin n_fail++; $display("FAIL parity_err_count: got %0d expected 1", pe_cnt); end
      n_checks++; if (same_cnt != 1) begin n_fail++; $display("FAIL parity_same_cycle: got %0d expected 1", same_cnt); end
      n_checks++; if (data !== 8'h07) begin n_fail++; $display("FAIL parity_data: got %0h expected 07", data); end
   endtask
`endif

   task automatic test_pulse_width();
      n_checks++; if (dbl_cnt != 0) begin n_fail++; $display("FAIL pulse_width: got %0d long pulses expected 0", dbl_cnt); end
   endtask

   initial begin
      repeat (3) @(negedge sysclk);
      test_reset();
      rst_n = 1'b1;
      repeat (5) @(negedge sysclk);
      test_single();
      test_glitch();
      test_frame_err();
      test_back_to_back();
      test_reset_midframe();
`ifdef CEREAL_RX_PARITY_EN
      test_parity();
`endif
      test_pulse_width();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
